// File: rtl/reg_bank_rw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_rw_pkg
// Description : Shared constants for the MIPS register bank and the WR mux
//               that selects the write-back destination index.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_rw_pkg;

  // Default geometry of the register bank
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architecturally special register indices
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  // Value loaded into $sp on reset
  localparam int SP_RESET_DEF = 227;

  // WR-mux select encoding, shared with the mux feeding WriteReg
  typedef enum logic [1:0] {
    WR_SEL_RT = 2'b00,
    WR_SEL_RD = 2'b01,
    WR_SEL_SP = 2'b10,
    WR_SEL_RA = 2'b11
  } wr_sel_e;

  // Destination index chosen by the WR mux for a given select
  function automatic logic [4:0] wr_mux_index(input wr_sel_e sel,
                                              input logic [4:0] rt,
                                              input logic [4:0] rd);
    logic [4:0] idx;
    idx = rt;
    case (sel)
      WR_SEL_RT: idx = rt;
      WR_SEL_RD: idx = rd;
      WR_SEL_SP: idx = 5'(REG_SP);
      WR_SEL_RA: idx = 5'(REG_RA);
      default:   idx = rt;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_rw_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_read_port
// Description : One registered read port of the register bank. Selects an
//               entry of the array view and registers it. When the macro
//               REG_BANK_BYPASS_EN is defined, a same-edge write to the read
//               index (other than index 0) is forwarded to the output.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_read_port
  import reg_bank_rw_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 1 << ADDR_W
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             rd_idx_i,
  input  logic [NREGS-1:0][DATA_W-1:0]  regs_i,
  input  logic                          wr_en_i,
  input  logic [ADDR_W-1:0]             wr_idx_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic [DATA_W-1:0]             rd_data_o
);

  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

`ifdef REG_BANK_BYPASS_EN
  logic bypass_hit;

  // A write to the same non-zero index this edge wins over the stored value
  assign bypass_hit = wr_en_i
                   && (wr_idx_i != ADDR_W'(REG_ZERO))
                   && (wr_idx_i == rd_idx_i);

  // Next read value: stored contents, or forwarded write data on a hit
  always_comb begin
    rd_data_d = regs_i[rd_idx_i];
    if (bypass_hit) begin
      rd_data_d = wr_data_i;
    end
  end
`else
  // Write-side inputs only matter when forwarding is built in
  logic unused_wr;
  assign unused_wr = &{1'b0, wr_en_i, wr_idx_i, wr_data_i};

  // Next read value: array contents as they stand before this edge's write
  always_comb begin
    rd_data_d = regs_i[rd_idx_i];
  end
`endif

  // Output register; reset clears it regardless of any pending read
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank_rw.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_rw
// Description : 32-entry register bank for the multicycle MIPS datapath with
//               one write port and two registered read ports. Register 0 is
//               hardwired to zero; $sp (29) resets to SP_RESET.
//               Optional macro: REG_BANK_BYPASS_EN enables write-to-read
//               forwarding on a same-edge index match.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_rw
  import reg_bank_rw_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEF)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int NREGS = 1 << ADDR_W;

  // Flat view of the array seen by both read ports; entry 0 is constant zero
  logic [NREGS-1:0][DATA_W-1:0] regs_view;

  assign regs_view[REG_ZERO] = '0;

  // Registers 1..NREGS-1 are real storage; index 0 has no flop so writes vanish
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_VAL = (gi == REG_SP) ? SP_RESET : '0;

    logic [DATA_W-1:0] reg_d;
    logic [DATA_W-1:0] reg_q;

    // Next state: load WriteData when this entry is the enabled write target
    always_comb begin
      reg_d = reg_q;
      if (RegWrite && (WriteReg == ADDR_W'(gi))) begin
        reg_d = WriteData;
      end
    end

    // Storage flop; reset overrides any write presented on the same edge
    always_ff @(posedge clk) begin
      if (reset) begin
        reg_q <= RST_VAL;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign regs_view[gi] = reg_q;
  end

  // Read port A (rs)
  reg_bank_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_rd_port_a (
    .clk       (clk),
    .reset     (reset),
    .rd_idx_i  (ReadReg1),
    .regs_i    (regs_view),
    .wr_en_i   (RegWrite),
    .wr_idx_i  (WriteReg),
    .wr_data_i (WriteData),
    .rd_data_o (ReadData1)
  );

  // Read port B (rt)
  reg_bank_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_rd_port_b (
    .clk       (clk),
    .reset     (reset),
    .rd_idx_i  (ReadReg2),
    .regs_i    (regs_view),
    .wr_en_i   (RegWrite),
    .wr_idx_i  (WriteReg),
    .wr_data_i (WriteData),
    .rd_data_o (ReadData2)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_rw.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_rw
// Description : Directed self-checking bench for reg_bank_rw.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_rw;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int n_tests;
  int n_fail;

  reg_bank_rw #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .SP_RESET (32'd227)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write (or no write) plus both read indices for the next edge
  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    RegWrite  = we;
    WriteReg  = wr;
    WriteData = wd;
    ReadReg1  = r1;
    ReadReg2  = r2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with $sp on port A: outputs must still be zero during reset
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
    tick();
    check("rst_rd1", ReadData1, 32'h0);
    check("rst_rd2", ReadData2, 32'h0);

    // First post-reset read: $sp holds SP_RESET, r5 holds zero
    reset = 1'b0;
    tick();
    check("sp_reset", ReadData1, 32'd227);
    check("r5_reset", ReadData2, 32'h0);

    // Write r9 while reading it at the same edge
    drive(1'b1, 5'd9, 32'hAAAA_5555, 5'd9, 5'd0);
    tick();
`ifdef REG_BANK_BYPASS_EN
    check("r9_same_edge", ReadData1, 32'hAAAA_5555);
`else
    check("r9_same_edge", ReadData1, 32'h0);
`endif
    drive(1'b0, 5'd9, 32'h1234_5678, 5'd9, 5'd0);
    tick();
    check("r9_read", ReadData1, 32'hAAAA_5555);
    check("r0_port2", ReadData2, 32'h0);

    // RegWrite low must not disturb r9 despite pending index/data
    tick();
    check("r9_no_we", ReadData1, 32'hAAAA_5555);

    // Write to index 0 is dropped on both ports
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    tick();
    check("r0_bypass_rd1", ReadData1, 32'h0);
    check("r0_bypass_rd2", ReadData2, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    check("r0_rd1", ReadData1, 32'h0);
    check("r0_rd2", ReadData2, 32'h0);

    // $ra and $sp write-back
    drive(1'b1, 5'd31, 32'h0000_0040, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd29, 32'h0000_00E0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd29);
    tick();
    check("ra_read", ReadData1, 32'h0000_0040);
    check("sp_read", ReadData2, 32'h0000_00E0);

    // Same index on both ports
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    tick();
    check("same_idx_rd1", ReadData1, 32'h0000_0040);
    check("same_idx_rd2", ReadData2, 32'h0000_0040);

    // Same-edge read/write of r21: old value 7, new value 12
    drive(1'b1, 5'd21, 32'd7, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd21, 32'd12, 5'd21, 5'd9);
    tick();
`ifdef REG_BANK_BYPASS_EN
    check("r21_raw", ReadData1, 32'd12);
`else
    check("r21_raw", ReadData1, 32'd7);
`endif
    check("r9_other_port", ReadData2, 32'hAAAA_5555);
    drive(1'b0, 5'd0, 32'h0, 5'd21, 5'd21);
    tick();
    check("r21_next", ReadData1, 32'd12);
    check("r21_next_rd2", ReadData2, 32'd12);

    // Reset versus a simultaneous write to r9
    reset = 1'b1;
    drive(1'b1, 5'd9, 32'd5, 5'd9, 5'd21);
    tick();
    check("rst_wr_rd1", ReadData1, 32'h0);
    check("rst_wr_rd2", ReadData2, 32'h0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd29);
    tick();
    check("r9_after_rst", ReadData1, 32'h0);
    check("sp_after_rst", ReadData2, 32'd227);
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd21);
    tick();
    check("ra_after_rst", ReadData1, 32'h0);
    check("r21_after_rst", ReadData2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
